// File: rtl/processador_pio_arb_pkg.sv
// Shared types and constants for the PIO arbiter: FSM states, PIO register address, hold counter width.
package processador_pio_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2,
    HOLD  = 2'd3
  } arb_state_e;

  localparam logic [1:0] PIO_DATA_ADDR = 2'd0;
  localparam int         HOLD_CNT_W    = 16;

endpackage

// File: rtl/processador_rr_picker.sv
// Round-robin picker: first set request at or above ptr, wrapping NREQ-1 -> 0. Pure combinational.
module processador_rr_picker
  import processador_pio_arb_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int IDX_W = 2
) (
  input  logic [NREQ-1:0]  req,
  input  logic [IDX_W-1:0] ptr,
  output logic             grant_valid,
  output logic [IDX_W-1:0] grant_idx
);

  int               pos;
  logic [IDX_W-1:0] cand;

  // Scan from the farthest offset down so the nearest request to ptr wins last.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = ptr;
    pos         = 0;
    cand        = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      pos = int'(ptr) + k;
      if (pos >= NREQ) pos = pos - NREQ;
      cand = IDX_W'(pos);
      if (req[cand]) begin
        grant_valid = 1'b1;
        grant_idx   = cand;
      end
    end
  end

endmodule

// File: rtl/processador_pio_arbiter.sv
// Avalon-MM master sharing one PIO data register among NREQ requesters, round-robin, one write per grant.
// Define PIO_ARB_READBACK_EN to verify each write with a read cycle and raise a sticky err on mismatch.
module processador_pio_arbiter
  import processador_pio_arb_pkg::*;
#(
  parameter int NREQ     = 4,
  parameter int DATA_W   = 4,
  parameter int MIN_HOLD = 0
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NREQ-1:0]          req,
  input  logic [NREQ*DATA_W-1:0]   req_data,
  output logic [NREQ-1:0]          ack,
  output logic                     busy,
  output logic                     err,
  input  logic                     err_clr,
  output logic [1:0]               avm_address,
  output logic                     avm_chipselect,
  output logic                     avm_write_n,
  output logic [31:0]              avm_writedata,
  input  logic [31:0]              avm_readdata
);

  localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [HOLD_CNT_W-1:0] HOLD_LOAD =
    (MIN_HOLD > 0) ? HOLD_CNT_W'(MIN_HOLD - 1) : '0;
  localparam logic [HOLD_CNT_W-1:0] HOLD_ONE = HOLD_CNT_W'(1);

  arb_state_e              state_q, state_d;
  logic [IDX_W-1:0]        ptr_q, ptr_d;
  logic [IDX_W-1:0]        grant_q, grant_d;
  logic [DATA_W-1:0]       data_q, data_d;
  logic [HOLD_CNT_W-1:0]   hold_cnt_q, hold_cnt_d;
  logic                    err_q, err_d;

  logic                    pick_vld;
  logic [IDX_W-1:0]        pick_idx;
  logic [DATA_W-1:0]       slot [NREQ];
  logic                    access_done;
  logic                    unused_inputs;

  for (genvar g = 0; g < NREQ; g++) begin : g_slot
    assign slot[g] = req_data[g*DATA_W +: DATA_W];
  end

  processador_rr_picker #(
    .NREQ  (NREQ),
    .IDX_W (IDX_W)
  ) u_picker (
    .req         (req),
    .ptr         (ptr_q),
    .grant_valid (pick_vld),
    .grant_idx   (pick_idx)
  );

`ifdef PIO_ARB_READBACK_EN
  assign access_done = (state_q == READ);
`else
  assign access_done = (state_q == WRITE);
`endif

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    grant_d    = grant_q;
    data_d     = data_q;
    hold_cnt_d = hold_cnt_q;
    err_d      = err_q;

    case (state_q)
      IDLE: begin
        if (pick_vld) begin
          grant_d = pick_idx;
          data_d  = slot[pick_idx];
          ptr_d   = (int'(pick_idx) == NREQ - 1) ? '0 : pick_idx + IDX_W'(1);
          state_d = WRITE;
        end
      end
      WRITE: begin
`ifdef PIO_ARB_READBACK_EN
        state_d = READ;
`else
        if (MIN_HOLD > 0) begin
          state_d    = HOLD;
          hold_cnt_d = HOLD_LOAD;
        end else begin
          state_d = IDLE;
        end
`endif
      end
      READ: begin
        if (MIN_HOLD > 0) begin
          state_d    = HOLD;
          hold_cnt_d = HOLD_LOAD;
        end else begin
          state_d = IDLE;
        end
      end
      HOLD: begin
        if (hold_cnt_q == '0) state_d = IDLE;
        else                  hold_cnt_d = hold_cnt_q - HOLD_ONE;
      end
      default: state_d = IDLE;
    endcase

`ifdef PIO_ARB_READBACK_EN
    // Clear first so a same-cycle mismatch wins.
    if (err_clr) err_d = 1'b0;
    if (state_q == READ && avm_readdata[DATA_W-1:0] != data_q) err_d = 1'b1;
`else
    err_d = 1'b0;
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      ptr_q      <= '0;
      grant_q    <= '0;
      data_q     <= '0;
      hold_cnt_q <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      grant_q    <= grant_d;
      data_q     <= data_d;
      hold_cnt_q <= hold_cnt_d;
      err_q      <= err_d;
    end
  end

  always_comb begin
    ack = '0;
    if (access_done) ack[grant_q] = 1'b1;
  end

  assign busy           = (state_q != IDLE);
  assign err            = err_q;
  assign avm_address    = PIO_DATA_ADDR;
  assign avm_chipselect = (state_q == WRITE) || (state_q == READ);
  assign avm_write_n    = (state_q != WRITE);
  assign avm_writedata  = 32'(data_q);
  assign unused_inputs  = ^{err_clr, avm_readdata};

endmodule
